button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer_if.sv | 25 ++
 rtl/button_debouncer.sv | 110 +++++++++++
 tb/tb_button_debouncer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Push-button debouncer signal bundle.
// slave: debouncer side, master: button/consumer side.
interface button_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_rise,
    input  btn_fall,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_rise,
    output btn_fall,
    output busy
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchronizer followed by
// a four-state qualification FSM with rise/fall pulses.
module button_debouncer #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input logic clk,
  input logic rst_n,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Any reversion during WAIT_* drops back to idle with
  // a cleared count, so requalification starts from 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (sync2_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2_q) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2_q) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.busy      = (state_q == WAIT_HIGH) ||
                         (state_q == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer, STABLE_CYCLES=4.
// Edge k counts from the first edge after the stimulus change.
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  button_debouncer_if dbg_if ();

  button_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_W        (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dbg_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic b);
    dbg_if.btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string tag,
    input logic  lvl,
    input logic  rise,
    input logic  fall,
    input logic  busy
  );
    check({tag, "_lvl"},  32'(dbg_if.btn_level), 32'(lvl));
    check({tag, "_rise"}, 32'(dbg_if.btn_rise),  32'(rise));
    check({tag, "_fall"}, 32'(dbg_if.btn_fall),  32'(fall));
    check({tag, "_busy"}, 32'(dbg_if.busy),      32'(busy));
  endtask

  initial begin
    logic prev;
    logic b;
    int   len;
    int   cyc;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    dbg_if.btn_in = 1'b0;

    step(1'b0);
    step(1'b0);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      chk_all("press", k >= 6, k == 6, 1'b0,
              k >= 3 && k <= 5);
    end

    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      chk_all("release", k < 6, 1'b0, k == 6,
              k >= 3 && k <= 5);
    end

    for (int k = 1; k <= 11; k++) begin
      step(k != 3);
      check("bounce_rise", 32'(dbg_if.btn_rise),
            32'(k == 9));
      check("bounce_lvl", 32'(dbg_if.btn_level),
            32'(k >= 9));
      check("bounce_fall", 32'(dbg_if.btn_fall), 32'(0));
    end

    for (int k = 1; k <= 8; k++) begin
      step(1'b0);
      check("rel2_fall", 32'(dbg_if.btn_fall),
            32'(k == 6));
      check("rel2_lvl", 32'(dbg_if.btn_level),
            32'(k < 6));
    end

    for (int k = 1; k <= 10; k++) begin
      step(k <= 3);
      chk_all("glitch", 1'b0, 1'b0, 1'b0,
              k >= 3 && k <= 5);
    end

    for (int k = 1; k <= 4; k++) step(1'b1);
    check("mid_busy", 32'(dbg_if.busy), 32'(1));
    rst_n = 1'b0;
    step(1'b1);
    chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1);
      chk_all("post_rst", k >= 6, k == 6, 1'b0,
              k >= 3 && k <= 5);
    end

    for (int k = 1; k <= 8; k++) step(1'b0);
    check("pre_soak_lvl", 32'(dbg_if.btn_level), 32'(0));

    b   = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      b   = ~b;
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        prev = dbg_if.btn_level;
        step(b);
        cyc++;
        check("soak_lvl", 32'(dbg_if.btn_level), 32'(0));
        check("sb_rise", 32'(dbg_if.btn_rise),
              32'(dbg_if.btn_level & ~prev));
        check("sb_fall", 32'(dbg_if.btn_fall),
              32'(~dbg_if.btn_level & prev));
        check("sb_excl",
              32'(dbg_if.btn_rise & dbg_if.btn_fall), 32'(0));
      end
    end
    for (int k = 1; k <= 8; k++) step(1'b0);
    chk_all("soak_end", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
